// File: rtl/wb_reg_arbiter.sv
// wb_reg_arbiter: round-robin two-master Wishbone arbiter for the register block slave port,
// grant locked per master cycle, with a watchdog that force-terminates unacknowledged accesses.
module wb_reg_arbiter #(
    parameter int                   ADDRWIDTH     = 7,
    parameter int                   DATAWIDTH     = 32,
    parameter int                   TIMEOUT_CNT   = 15,
    parameter logic [DATAWIDTH-1:0] TIMEOUT_VALUE = 32'hBADFABAC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_n_i,
    input  logic [ADDRWIDTH-1:0] m0_ADR_i,
    input  logic                 m0_CYC_i,
    input  logic                 m0_STB_i,
    input  logic                 m0_WE_i,
    input  logic [3:0]           m0_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0] m0_DAT_i,
    output logic [DATAWIDTH-1:0] m0_DAT_o,
    output logic                 m0_ACK_o,
    input  logic [ADDRWIDTH-1:0] m1_ADR_i,
    input  logic                 m1_CYC_i,
    input  logic                 m1_STB_i,
    input  logic                 m1_WE_i,
    input  logic [3:0]           m1_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0] m1_DAT_i,
    output logic [DATAWIDTH-1:0] m1_DAT_o,
    output logic                 m1_ACK_o,
    output logic [ADDRWIDTH-1:0] s_ADR_o,
    output logic                 s_CYC_o,
    output logic                 s_STB_o,
    output logic                 s_WE_o,
    output logic [3:0]           s_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] s_DAT_o,
    input  logic [DATAWIDTH-1:0] s_DAT_i,
    input  logic                 s_ACK_i,
    output logic [1:0]           grant_o,
    output logic                 timeout_o
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       req0, req1, own0, own1, own_stb, forced_ack;

    assign req0 = m0_CYC_i & m0_STB_i;
    assign req1 = m1_CYC_i & m1_STB_i;
    assign own0 = state_q == OWN0;
    assign own1 = state_q == OWN1;
    assign own_stb = own0 ? m0_STB_i : own1 & m1_STB_i;
    // A real ACK in the threshold cycle suppresses the forced termination
    assign forced_ack = own_stb & ~s_ACK_i & (cnt_q == 8'(TIMEOUT_CNT));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0 & (~req1 | last_q))
                    state_d = OWN0;
                else if (req1)
                    state_d = OWN1;
            end
            OWN0: begin
                if (!m0_CYC_i) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_CYC_i) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (state_q == IDLE || s_ACK_i || forced_ack) ? 8'd0 :
                own_stb ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_ADR_o      = own0 ? m0_ADR_i      : own1 ? m1_ADR_i      : '0;
    assign s_CYC_o      = own0 ? m0_CYC_i      : own1 & m1_CYC_i;
    assign s_STB_o      = own_stb & ~forced_ack;
    assign s_WE_o       = own0 ? m0_WE_i       : own1 & m1_WE_i;
    assign s_BYTE_STB_o = own0 ? m0_BYTE_STB_i : own1 ? m1_BYTE_STB_i : 4'd0;
    assign s_DAT_o      = own0 ? m0_DAT_i      : own1 ? m1_DAT_i      : '0;

    assign m0_ACK_o  = own0 & (s_ACK_i | forced_ack);
    assign m1_ACK_o  = own1 & (s_ACK_i | forced_ack);
    assign m0_DAT_o  = (own0 & forced_ack) ? TIMEOUT_VALUE : s_DAT_i;
    assign m1_DAT_o  = (own1 & forced_ack) ? TIMEOUT_VALUE : s_DAT_i;
    assign grant_o   = {own1, own0};
    assign timeout_o = forced_ack;
endmodule

// File: tb/tb_wb_reg_arbiter.sv
// tb_wb_reg_arbiter: directed vector table for arbitration plus hand sequences for
// watchdog, ACK/timeout race and asynchronous reset.
module tb_wb_reg_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  m0_adr = 7'h02, m1_adr = 7'h05;
    logic        m0_cyc = 1'b0, m0_stb = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
    logic        m0_we = 1'b1, m1_we = 1'b0;
    logic [3:0]  m0_be = 4'h3, m1_be = 4'hC;
    logic [31:0] m0_dat = 32'hA5A50000, m1_dat = 32'h00005A5A;
    logic [31:0] m0_rdat, m1_rdat, s_dat_o, s_dat_i = 32'h12345678;
    logic        m0_ack, m1_ack, s_ack = 1'b0;
    logic [6:0]  s_adr;
    logic        s_cyc, s_stb, s_we, timeout;
    logic [3:0]  s_be;
    logic [1:0]  grant;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic       c0, s0, c1, s1, ack;
        logic [1:0] g;
        logic       a0, a1, to, sstb;
        logic [6:0] adr;
    } vec_t;

    vec_t        vecs [20];
    logic [12:0] act, exp_v;

    always #5 clk = ~clk;

    wb_reg_arbiter dut (
        .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n),
        .m0_ADR_i(m0_adr), .m0_CYC_i(m0_cyc), .m0_STB_i(m0_stb), .m0_WE_i(m0_we),
        .m0_BYTE_STB_i(m0_be), .m0_DAT_i(m0_dat), .m0_DAT_o(m0_rdat), .m0_ACK_o(m0_ack),
        .m1_ADR_i(m1_adr), .m1_CYC_i(m1_cyc), .m1_STB_i(m1_stb), .m1_WE_i(m1_we),
        .m1_BYTE_STB_i(m1_be), .m1_DAT_i(m1_dat), .m1_DAT_o(m1_rdat), .m1_ACK_o(m1_ack),
        .s_ADR_o(s_adr), .s_CYC_o(s_cyc), .s_STB_o(s_stb), .s_WE_o(s_we),
        .s_BYTE_STB_o(s_be), .s_DAT_o(s_dat_o), .s_DAT_i(s_dat_i), .s_ACK_i(s_ack),
        .grant_o(grant), .timeout_o(timeout)
    );

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic drive(input logic c0, input logic s0, input logic c1, input logic s1, input logic ack);
        m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; s_ack = ack;
    endtask

    initial begin
        // {c0 s0 c1 s1 ack}, grant, {a0 a1 to sstb}, s_ADR_o
        vecs[0]  = {5'b00000, 2'b00, 4'b0000, 7'h00};
        vecs[1]  = {5'b11110, 2'b00, 4'b0000, 7'h00};
        vecs[2]  = {5'b11111, 2'b01, 4'b1001, 7'h02};
        vecs[3]  = {5'b00110, 2'b01, 4'b0000, 7'h02};
        vecs[4]  = {5'b00110, 2'b00, 4'b0000, 7'h00};
        vecs[5]  = {5'b00111, 2'b10, 4'b0101, 7'h05};
        vecs[6]  = {5'b00000, 2'b10, 4'b0000, 7'h05};
        vecs[7]  = {5'b11110, 2'b00, 4'b0000, 7'h00};
        vecs[8]  = {5'b11111, 2'b01, 4'b1001, 7'h02};
        vecs[9]  = {5'b00000, 2'b01, 4'b0000, 7'h02};
        vecs[10] = {5'b00110, 2'b00, 4'b0000, 7'h00};
        vecs[11] = {5'b11111, 2'b10, 4'b0101, 7'h05};
        vecs[12] = {5'b11100, 2'b10, 4'b0000, 7'h05};
        vecs[13] = {5'b11111, 2'b10, 4'b0101, 7'h05};
        vecs[14] = {5'b11111, 2'b10, 4'b0101, 7'h05};
        vecs[15] = {5'b11000, 2'b10, 4'b0000, 7'h05};
        vecs[16] = {5'b11000, 2'b00, 4'b0000, 7'h00};
        vecs[17] = {5'b11001, 2'b01, 4'b1001, 7'h02};
        vecs[18] = {5'b00000, 2'b01, 4'b0000, 7'h02};
        vecs[19] = {5'b00000, 2'b00, 4'b0000, 7'h00};

        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_out", 64'({s_cyc, s_stb, s_we, s_be, s_adr, s_dat_o, grant, m0_ack, m1_ack, timeout}), 64'(0));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1, vecs[i].ack);
            #1;
            act   = {grant, m0_ack, m1_ack, timeout, s_stb, s_adr};
            exp_v = {vecs[i].g, vecs[i].a0, vecs[i].a1, vecs[i].to, vecs[i].sstb, vecs[i].adr};
            nvec++;
            if (act !== exp_v) begin
                nerr++;
                $display("FAIL vec%0d: got %b want %b", i, act, exp_v);
            end
            if (i == 2) chk("vec2_rdata", 64'(m0_rdat), 64'(32'h12345678));
        end

        // Slave never answers: forced ACK in the 16th STB cycle of the grant
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("wd_idle", 64'(grant), 64'(2'b00));
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            if (k == 1)
                chk("wd_pass", 64'({s_cyc, s_we, s_be, s_dat_o}), 64'({1'b1, 1'b1, 4'h3, 32'hA5A50000}));
            if (k < 16)
                chk("wd_wait", 64'({m0_ack, timeout, s_stb}), 64'(3'b001));
            else begin
                chk("wd_fire", 64'({m0_ack, m1_ack, timeout, s_stb}), 64'(4'b1010));
                chk("wd_data", 64'(m0_rdat), 64'(32'hBADFABAC));
                chk("wd_m1data", 64'(m1_rdat), 64'(32'h12345678));
            end
        end
        @(negedge clk);
        #1 chk("wd_rearm", 64'({m0_ack, timeout, s_stb}), 64'(3'b001));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Real ACK lands exactly on the threshold cycle
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 16) begin
                s_ack = 1'b1;
                s_dat_i = 32'hCAFE0001;
            end
            #1;
        end
        chk("race", 64'({m0_ack, timeout, s_stb, m0_rdat}), 64'({3'b101, 32'hCAFE0001}));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Asynchronous reset while m1 owns with STB high
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #1 chk("rst_own", 64'({grant, s_cyc, s_stb}), 64'(4'b1011));
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 64'({s_cyc, s_stb, grant, m1_ack}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 chk("rst_idle", 64'(grant), 64'(2'b00));
        @(negedge clk);
        #1 chk("rst_tie", 64'({grant, s_adr}), 64'({2'b01, 7'h02}));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
